// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. Registers the execute-stage result and drives the
// register-file write port. It also issues the PC redirect back to fetch on a
// taken JMP, and owns the sticky machine-halt state. It counts retired
// instructions and records the PC of the last one.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   in_*            : valid/ready handshake and instruction fields from execute
//   rf_we/waddr/wdata
//                   : register-file write port, 1 cycle after accept
//   redirect_valid/pc
//                   : one-cycle redirect pulse and its target, to fetch
//   halted          : sticky halt flag
//   retire_count    : saturating count of retired instructions
//   retire_pc       : PC of the last retired instruction
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_RUN    | accepting instructions, one per cycle
//   S_REDIR  | redirect pulse cycle; wrong-path instruction is refused
//   S_HALTED | HALT retired; nothing accepted until reset
// ---------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_is_jmp,
    input  logic [DATA_W-1:0] in_jmp_target,
    input  logic              in_is_halt,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_count,
    output logic [DATA_W-1:0] retire_pc
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_REDIR  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               accept;
    logic               rf_we_q;
    logic [REG_AW-1:0]  rf_waddr_q;
    logic [DATA_W-1:0]  rf_wdata_q;
    logic               redirect_valid_q;
    logic [DATA_W-1:0]  redirect_pc_q;
    logic [CNT_W-1:0]   retire_count_q;
    logic [DATA_W-1:0]  retire_pc_q;

    // Ready is gated by rst so nothing looks acceptable while reset is held;
    // it rises as soon as reset is released.
    assign in_ready = (state_q == S_RUN) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (accept) begin
                    // HALT wins over JMP when both are flagged.
                    if (in_is_halt) begin
                        state_d = S_HALTED;
                    end else if (in_is_jmp) begin
                        state_d = S_REDIR;
                    end
                end
            end
            S_REDIR:  state_d = S_RUN;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q          <= 1'b0;
            rf_waddr_q       <= '0;
            rf_wdata_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            retire_count_q   <= '0;
            retire_pc_q      <= '0;
        end else begin
            rf_we_q          <= accept && in_wr_en && !in_is_halt;
            redirect_valid_q <= accept && in_is_jmp && !in_is_halt;
            if (accept) begin
                rf_waddr_q  <= in_dest;
                rf_wdata_q  <= in_result;
                retire_pc_q <= in_pc;
                if (in_is_jmp && !in_is_halt) begin
                    redirect_pc_q <= in_jmp_target;
                end
                // Saturate instead of wrapping.
                if (retire_count_q != {CNT_W{1'b1}}) begin
                    retire_count_q <= retire_count_q + 1'b1;
                end
            end
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign halted         = (state_q == S_HALTED);
    assign retire_count   = retire_count_q;
    assign retire_pc      = retire_pc_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_result;
    logic [2:0]  in_dest;
    logic        in_wr_en;
    logic        in_is_jmp;
    logic [31:0] in_jmp_target;
    logic        in_is_halt;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] retire_count;
    logic [31:0] retire_pc;

    // Narrow-counter instance for the saturation scenario.
    logic        sat_valid;
    logic        sat_ready;
    logic        sat_rf_we;
    logic [2:0]  sat_rf_waddr;
    logic [31:0] sat_rf_wdata;
    logic        sat_redirect_valid;
    logic [31:0] sat_redirect_pc;
    logic        sat_halted;
    logic [3:0]  sat_count;
    logic [31:0] sat_retire_pc;

    int checks = 0;
    int errors = 0;

    writeback_stage u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_result(in_result), .in_dest(in_dest),
        .in_wr_en(in_wr_en), .in_is_jmp(in_is_jmp),
        .in_jmp_target(in_jmp_target), .in_is_halt(in_is_halt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .retire_count(retire_count), .retire_pc(retire_pc)
    );

    writeback_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(sat_valid), .in_ready(sat_ready),
        .in_pc(in_pc), .in_result(in_result), .in_dest(in_dest),
        .in_wr_en(in_wr_en), .in_is_jmp(in_is_jmp),
        .in_jmp_target(in_jmp_target), .in_is_halt(in_is_halt),
        .rf_we(sat_rf_we), .rf_waddr(sat_rf_waddr), .rf_wdata(sat_rf_wdata),
        .redirect_valid(sat_redirect_valid), .redirect_pc(sat_redirect_pc),
        .halted(sat_halted), .retire_count(sat_count), .retire_pc(sat_retire_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] res,
                         input logic [2:0] dest, input logic wr, input logic jmp,
                         input logic [31:0] tgt, input logic hlt);
        in_valid      = v;
        in_pc         = pc;
        in_result     = res;
        in_dest       = dest;
        in_wr_en      = wr;
        in_is_jmp     = jmp;
        in_jmp_target = tgt;
        in_is_halt    = hlt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        sat_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #3;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc, halted, retire_count, retire_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b waddr=%h wdata=%h rv=%b rpc=%h halted=%b cnt=%h rtpc=%h, need all 0",
                     rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc, halted, retire_count, retire_pc);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_held: got %b need 0", in_ready);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_release: got %b need 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  dests [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] ress  [3] = '{32'h5, 32'hA, 32'hFFFF_FFFF};
        apply_reset();
        step();
        drive(1'b1, 32'h0, ress[0], dests[0], 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b need 1", i, in_ready);
            end
            step();
            if (i < 2) drive(1'b1, 32'h4 * (i + 1), ress[i+1], dests[i+1], 1'b1, 1'b0, 32'h0, 1'b0);
            else idle();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, dests[i], ress[i]}) begin
                errors++;
                $display("FAIL b2b_write[%0d]: got we=%b a=%h d=%h need we=1 a=%h d=%h",
                         i, rf_we, rf_waddr, rf_wdata, dests[i], ress[i]);
            end
        end
        step();
        checks++;
        if (rf_we !== 1'b0 || retire_count !== 32'd3 || retire_pc !== 32'h8) begin
            errors++;
            $display("FAIL b2b_final: got we=%b cnt=%0d rpc=%h need we=0 cnt=3 rpc=8", rf_we, retire_count, retire_pc);
        end
    endtask

    task automatic test_jmp();
        apply_reset();
        step();
        drive(1'b1, 32'h100, 32'h0, 3'd0, 1'b0, 1'b1, 32'h120, 1'b0);
        step();
        drive(1'b1, 32'h120, 32'h77, 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({redirect_valid, redirect_pc, in_ready, rf_we} !== {1'b1, 32'h120, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL jmp_redirect: got rv=%b rpc=%h rdy=%b we=%b need rv=1 rpc=120 rdy=0 we=0",
                     redirect_valid, redirect_pc, in_ready, rf_we);
        end
        checks++;
        if (retire_count !== 32'd1 || retire_pc !== 32'h100) begin
            errors++;
            $display("FAIL jmp_retire: got cnt=%0d rpc=%h need cnt=1 rpc=100", retire_count, retire_pc);
        end
        step();
        idle();
        checks++;
        if ({redirect_valid, redirect_pc, in_ready, rf_we} !== {1'b0, 32'h120, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL jmp_after: got rv=%b rpc=%h rdy=%b we=%b need rv=0 rpc=120 rdy=1 we=0",
                     redirect_valid, redirect_pc, in_ready, rf_we);
        end
        checks++;
        if (retire_count !== 32'd1) begin
            errors++;
            $display("FAIL jmp_wrongpath_count: got %0d need 1", retire_count);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        step();
        drive(1'b1, 32'h10, 32'h9, 3'd5, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h40, 32'h55, 3'd6, 1'b1, 1'b1, 32'h80, 1'b1);
        checks++;
        if (halted !== 1'b0 || retire_count !== 32'd1) begin
            errors++;
            $display("FAIL halt_pre: got halted=%b cnt=%0d need halted=0 cnt=1", halted, retire_count);
        end
        step();
        drive(1'b1, 32'h44, 32'h66, 3'd2, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({halted, in_ready, rf_we, redirect_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL halt_enter: got halted=%b rdy=%b we=%b rv=%b need 1 0 0 0",
                     halted, in_ready, rf_we, redirect_valid);
        end
        checks++;
        if (retire_count !== 32'd2 || retire_pc !== 32'h40 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL halt_retire: got cnt=%0d rpc=%h redir_pc=%h need cnt=2 rpc=40 redir_pc=0",
                     retire_count, retire_pc, redirect_pc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({halted, in_ready, rf_we, redirect_valid} !== 4'b1000 || retire_count !== 32'd2 || retire_pc !== 32'h40) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got halted=%b rdy=%b we=%b rv=%b cnt=%0d rpc=%h need 1 0 0 0 cnt=2 rpc=40",
                         i, halted, in_ready, rf_we, redirect_valid, retire_count, retire_pc);
            end
        end
        idle();
    endtask

    task automatic test_valid_toggle();
        logic exp_we;
        apply_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            exp_we = (i % 2 == 0);
            if (exp_we) drive(1'b1, 32'h200 + i, 32'h1234, 3'd7, 1'b1, 1'b0, 32'h0, 1'b0);
            else        drive(1'b0, 32'h300, 32'hDEAD, 3'd1, 1'b1, 1'b0, 32'h0, 1'b0);
            step();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {exp_we, 3'd7, 32'h1234}) begin
                errors++;
                $display("FAIL toggle[%0d]: got we=%b a=%h d=%h need we=%b a=7 d=1234",
                         i, rf_we, rf_waddr, rf_wdata, exp_we);
            end
        end
        idle();
        checks++;
        if (retire_count !== 32'd2 || retire_pc !== 32'h202) begin
            errors++;
            $display("FAIL toggle_count: got cnt=%0d rpc=%h need cnt=2 rpc=202", retire_count, retire_pc);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        apply_reset();
        step();
        drive(1'b0, 32'h500, 32'h1, 3'd1, 1'b1, 1'b0, 32'h0, 1'b0);
        sat_valid = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            exp_cnt = (i > 15) ? 15 : i;
            checks++;
            if (sat_count !== exp_cnt[3:0]) begin
                errors++;
                $display("FAIL sat_count[%0d]: got %0d need %0d", i, sat_count, exp_cnt);
            end
        end
        idle();
        step();
        checks++;
        if (sat_count !== 4'd15 || retire_count !== 32'd0) begin
            errors++;
            $display("FAIL sat_hold: got sat=%0d main=%0d need sat=15 main=0", sat_count, retire_count);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step();
        drive(1'b1, 32'h100, 32'h0, 3'd0, 1'b0, 1'b1, 32'h120, 1'b0);
        step();
        idle();
        checks++;
        if (redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_setup_redir: got rv=%b need 1", redirect_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({redirect_valid, redirect_pc, retire_count, in_ready} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_redir: got rv=%b rpc=%h cnt=%0d rdy=%b need 0 0 0 0",
                     redirect_valid, redirect_pc, retire_count, in_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_redir_release: got rdy=%b rv=%b need rdy=1 rv=0", in_ready, redirect_valid);
        end
        step();
        drive(1'b1, 32'h60, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        idle();
        checks++;
        if (halted !== 1'b1 || retire_count !== 32'd1) begin
            errors++;
            $display("FAIL async_setup_halt: got halted=%b cnt=%0d need 1 1", halted, retire_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({halted, retire_count, retire_pc, in_ready} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_halt: got halted=%b cnt=%0d rpc=%h rdy=%b need 0 0 0 0",
                     halted, retire_count, retire_pc, in_ready);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_halt_release: got rdy=%b need 1", in_ready);
        end
        step();
        checks++;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_halt_run: got halted=%b rdy=%b need 0 1", halted, in_ready);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_jmp();
        test_halt();
        test_valid_toggle();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; sits directly downstream of the execute stage.
- Consumes the execute stage's ALU/MOV result, jump target, is_jmp and is_halt, registers them, and drives the register-file write port.
- Drives the PC redirect back to fetch and owns the machine halt state.
- Uses a valid/ready handshake with the upstream pipeline latch.

Parameters:
- DATA_W, 32, width of result, PC and jump target
- REG_AW, 3, register-file address width (8 GPRs)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts this cycle; transfer when in_valid && in_ready
- in_pc  in  DATA_W  PC of the instruction
- in_result  in  DATA_W  execute result (ADD sum or MOV operand)
- in_dest  in  REG_AW  destination register
- in_wr_en  in  1  instruction writes in_dest
- in_is_jmp  in  1  instruction is a taken JMP
- in_jmp_target  in  DATA_W  pc + length + imm from execute
- in_is_halt  in  1  instruction is HALT
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc and flush younger instructions
- redirect_pc  out  DATA_W  redirect target
- halted  out  1  machine halted (sticky)
- retire_count  out  CNT_W  instructions retired
- retire_pc  out  DATA_W  PC of last retired instruction

Behaviour:
- Reset (asynchronous, active-high; all state and outputs clear immediately on assertion, independent of clk):
  - FSM goes to RUN.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - redirect_valid=0, redirect_pc=0.
  - halted=0, retire_count=0, retire_pc=0.
  - in_ready goes to 1 once rst deasserts.
- FSM states: RUN, REDIR, HALTED. in_ready=1 only in RUN (combinational from state). accept = in_valid && in_ready.
- RUN:
  - no accept -> stay in RUN.
  - accept with in_is_halt -> HALTED. Halt has priority over jmp if both are set.
  - accept with in_is_jmp (and not halt) -> REDIR.
  - otherwise stay in RUN.
- REDIR:
  - lasts exactly one cycle, then RUN.
  - in_ready=0, so the wrong-path instruction presented that cycle is not accepted.
  - upstream must flush it in response to redirect_valid.
- HALTED: in_ready=0, halted=1; held until reset. No further writes, redirects or retires.
- Register-file write, registered with 1-cycle latency from accept:
  - rf_we <= accept && in_wr_en && !in_is_halt.
  - rf_waddr <= in_dest and rf_wdata <= in_result, loaded on accept only; they hold their value otherwise.
  - rf_we is 0 on every cycle without an accept.
  - A JMP with in_wr_en=1 still writes.
  - A HALT never writes.
- Redirect:
  - redirect_valid <= accept && in_is_jmp && !in_is_halt; asserted exactly during the REDIR cycle.
  - redirect_pc <= in_jmp_target on that accept, held afterwards.
  - Arithmetic on in_jmp_target is modulo 2^DATA_W, passed through unchanged (wrap allowed, no check).
- halted: registered; rises the cycle after HALT is accepted. HALT is counted as retired.
- retire_count:
  - +1 per accept (ALU, MOV, JMP and HALT alike), visible the cycle after accept.
  - Saturates at 2^CNT_W-1; no wrap.
- retire_pc <= in_pc on each accept.
- Back-to-back accepts in RUN are allowed: one instruction per cycle, full throughput.
- Input fields are ignored when in_valid=0, and while in_ready=0.
- Reset asserted mid-REDIR or in HALTED: immediate return to reset values; any pending redirect pulse is cancelled.

Test Plan:
- Reset, then three back-to-back ALU ops (dest 1/2/3, results 0x5, 0xA, 0xFFFFFFFF, wr_en=1) -> rf_we high 3 consecutive cycles, each write 1 cycle after its accept; retire_count=3; in_ready stays 1.
- JMP at pc=0x100, target 0x120, wr_en=0, with an ALU op (dest 4) presented the next cycle -> redirect_valid one cycle with redirect_pc=0x120; in_ready=0 that cycle, so the ALU op is not accepted and no rf write occurs; in_ready=1 the cycle after; retire_count=1.
- HALT with in_wr_en=1 and in_is_jmp=1, followed by valid ALU ops -> no rf write, no redirect; halted=1 next cycle and stays; in_ready=0 forever; retire_count increments by exactly 1; retire_pc=halt pc.
- in_valid toggling 1,0,1,0 with MOV result 0x1234 to dest 7 -> writes only after valid cycles; rf_wdata holds 0x1234 between writes; rf_we=0 in the gaps.
- Preload retire_count near max (CNT_W=4 override, 16 accepts) -> count sticks at 15.
- Assert rst asynchronously (between clock edges) during REDIR and again while HALTED -> outputs clear without waiting for clk: redirect_valid=0, halted=0, count=0; after deassert, RUN and in_ready=1.
